// File: rtl/alu_seq_pkg.sv
// Shared ALU definitions: opcode encodings and sequencer state encodings.
package alu_seq_pkg;

  localparam int XLEN = 32;

  // ALU opcode encoding shared by every ALU client.
  localparam logic [3:0] ALUOP_ADD  = 4'd0;
  localparam logic [3:0] ALUOP_SUB  = 4'd1;
  localparam logic [3:0] ALUOP_SLL  = 4'd2;
  localparam logic [3:0] ALUOP_SLT  = 4'd3;
  localparam logic [3:0] ALUOP_SLTU = 4'd4;
  localparam logic [3:0] ALUOP_XOR  = 4'd5;
  localparam logic [3:0] ALUOP_SRL  = 4'd6;
  localparam logic [3:0] ALUOP_SRA  = 4'd7;
  localparam logic [3:0] ALUOP_OR   = 4'd8;
  localparam logic [3:0] ALUOP_AND  = 4'd9;

  // Sequencer states.
  typedef enum logic [1:0] {
    ALUSEQ_ST_IDLE  = 2'd0,
    ALUSEQ_ST_ISSUE = 2'd1,
    ALUSEQ_ST_WAIT  = 2'd2,
    ALUSEQ_ST_RESP  = 2'd3
  } aluseq_st_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request arbiter; round-robin on ties when RR=1, port 0 priority when RR=0.
module rr_arb2 #(
  parameter int RR = 1
) (
  input  logic       I_clk,
  input  logic       I_reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // Most recent winner; starts at 1 so port 0 wins the first tie.
  logic last_reg;

  // Grant selection: a lone request always wins, a tie goes to the other port.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = ((RR != 0) && (last_reg == 1'b0)) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember who won whenever a grant is issued.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      last_reg <= 1'b1;
    end else if (|gnt) begin
      last_reg <= gnt[1];
    end
  end

endmodule

// File: rtl/alu_seq.sv
// ALU sequencer: arbitrates two requesters, drives the ALU through its busy
// protocol, and returns a registered result on a valid/ready channel.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int RR      = 1,
  parameter int TIMEOUT = 40
) (
  input  logic            I_clk,
  input  logic            I_reset,
  input  logic            I_req0_valid,
  input  logic            I_req1_valid,
  output logic            O_req0_ready,
  output logic            O_req1_ready,
  input  logic [3:0]      I_req0_op,
  input  logic [3:0]      I_req1_op,
  input  logic [XLEN-1:0] I_req0_s1,
  input  logic [XLEN-1:0] I_req0_s2,
  input  logic [XLEN-1:0] I_req1_s1,
  input  logic [XLEN-1:0] I_req1_s2,
  output logic            O_alu_en,
  output logic [3:0]      O_alu_op,
  output logic [XLEN-1:0] O_alu_s1,
  output logic [XLEN-1:0] O_alu_s2,
  input  logic            I_alu_busy,
  input  logic [XLEN-1:0] I_alu_data,
  input  logic            I_alu_lt,
  input  logic            I_alu_ltu,
  input  logic            I_alu_eq,
  output logic            O_rsp_valid,
  input  logic            I_rsp_ready,
  output logic            O_rsp_id,
  output logic [XLEN-1:0] O_rsp_data,
  output logic            O_rsp_lt,
  output logic            O_rsp_ltu,
  output logic            O_rsp_eq,
  output logic            O_rsp_err
);

  // Last WAIT cycle index allowed before the operation is aborted.
  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

  aluseq_st_e      state_reg, state_next;
  logic [3:0]      op_reg;
  logic [XLEN-1:0] s1_reg, s2_reg;
  logic            id_reg;
  logic [5:0]      tmo_cnt_reg;
  logic [XLEN-1:0] rsp_data_reg;
  logic            rsp_lt_reg, rsp_ltu_reg, rsp_eq_reg, rsp_err_reg;

  logic       grant_en;
  logic [1:0] gnt;
  logic       capture, abort;

  // Grants are only offered while idle.
  assign grant_en = (state_reg == ALUSEQ_ST_IDLE);

  rr_arb2 #(.RR(RR)) u_arb (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .req     ({I_req1_valid, I_req0_valid}),
    .en      (grant_en),
    .gnt     (gnt)
  );

  assign O_req0_ready = gnt[0];
  assign O_req1_ready = gnt[1];
  assign O_alu_op     = op_reg;
  assign O_alu_s1     = s1_reg;
  assign O_alu_s2     = s2_reg;
  assign O_rsp_id     = id_reg;
  assign O_rsp_data   = rsp_data_reg;
  assign O_rsp_lt     = rsp_lt_reg;
  assign O_rsp_ltu    = rsp_ltu_reg;
  assign O_rsp_eq     = rsp_eq_reg;
  assign O_rsp_err    = rsp_err_reg;

  // Next-state and output decode; enable drops in the same cycle busy falls.
  always_comb begin
    state_next  = state_reg;
    O_alu_en    = 1'b0;
    O_rsp_valid = 1'b0;
    capture     = 1'b0;
    abort       = 1'b0;
    case (state_reg)
      ALUSEQ_ST_IDLE: begin
        if (|gnt) state_next = ALUSEQ_ST_ISSUE;
      end
      ALUSEQ_ST_ISSUE: begin
        O_alu_en   = 1'b1;
        state_next = ALUSEQ_ST_WAIT;
      end
      ALUSEQ_ST_WAIT: begin
        if (!I_alu_busy) begin
          capture    = 1'b1;
          state_next = ALUSEQ_ST_RESP;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          abort      = 1'b1;
          state_next = ALUSEQ_ST_RESP;
        end else begin
          O_alu_en = 1'b1;
        end
      end
      ALUSEQ_ST_RESP: begin
        O_rsp_valid = 1'b1;
        if (I_rsp_ready) state_next = ALUSEQ_ST_IDLE;
      end
      default: state_next = ALUSEQ_ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge I_clk) begin
    if (I_reset) state_reg <= ALUSEQ_ST_IDLE;
    else         state_reg <= state_next;
  end

  // Latch the winning request's payload at grant time.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      op_reg <= 4'd0;
      s1_reg <= '0;
      s2_reg <= '0;
      id_reg <= 1'b0;
    end else if (|gnt) begin
      op_reg <= gnt[1] ? I_req1_op : I_req0_op;
      s1_reg <= gnt[1] ? I_req1_s1 : I_req0_s1;
      s2_reg <= gnt[1] ? I_req1_s2 : I_req0_s2;
      id_reg <= gnt[1];
    end
  end

  // WAIT cycle counter, cleared while issuing.
  always_ff @(posedge I_clk) begin
    if (I_reset || state_reg == ALUSEQ_ST_ISSUE) tmo_cnt_reg <= 6'd0;
    else if (state_reg == ALUSEQ_ST_WAIT)        tmo_cnt_reg <= tmo_cnt_reg + 6'd1;
  end

  // Response registers: ALU result on completion, zeros plus error on abort.
  always_ff @(posedge I_clk) begin
    if (I_reset || abort) begin
      rsp_data_reg <= '0;
      rsp_lt_reg   <= 1'b0;
      rsp_ltu_reg  <= 1'b0;
      rsp_eq_reg   <= 1'b0;
      rsp_err_reg  <= abort && !I_reset;
    end else if (capture) begin
      rsp_data_reg <= I_alu_data;
      rsp_lt_reg   <= I_alu_lt;
      rsp_ltu_reg  <= I_alu_ltu;
      rsp_eq_reg   <= I_alu_eq;
      rsp_err_reg  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural multi-cycle ALU alongside.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rsp_ready, force_busy;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;

  logic        rdy0, rdy1, alu_en, alu_busy, rsp_valid, rsp_id;
  logic [3:0]  alu_op;
  logic [31:0] alu_s1, alu_s2, rsp_data;
  logic        rsp_lt, rsp_ltu, rsp_eq, rsp_err;

  // Second instance with fixed priority and an always-ready ALU.
  logic        b_rdy0, b_rdy1, b_en, b_rsp_valid, b_rsp_id;
  logic        b_lt, b_ltu, b_eq, b_err;
  logic [3:0]  b_op;
  logic [31:0] b_s1, b_s2, b_data;
  logic        b_busy_in = 1'b0;
  logic [31:0] b_data_in = 32'h0;

  // ALU model state.
  logic [5:0]  m_cnt;
  logic [31:0] m_data;
  logic        m_lt, m_ltu, m_eq;

  int n_pass = 0, n_total = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_seq #(.RR(1), .TIMEOUT(40)) dut (
    .I_clk(clk), .I_reset(rst),
    .I_req0_valid(v0), .I_req1_valid(v1),
    .O_req0_ready(rdy0), .O_req1_ready(rdy1),
    .I_req0_op(op0), .I_req1_op(op1),
    .I_req0_s1(a0), .I_req0_s2(b0), .I_req1_s1(a1), .I_req1_s2(b1),
    .O_alu_en(alu_en), .O_alu_op(alu_op), .O_alu_s1(alu_s1), .O_alu_s2(alu_s2),
    .I_alu_busy(alu_busy), .I_alu_data(m_data),
    .I_alu_lt(m_lt), .I_alu_ltu(m_ltu), .I_alu_eq(m_eq),
    .O_rsp_valid(rsp_valid), .I_rsp_ready(rsp_ready), .O_rsp_id(rsp_id),
    .O_rsp_data(rsp_data), .O_rsp_lt(rsp_lt), .O_rsp_ltu(rsp_ltu),
    .O_rsp_eq(rsp_eq), .O_rsp_err(rsp_err)
  );

  alu_seq #(.RR(0), .TIMEOUT(40)) dut_fix (
    .I_clk(clk), .I_reset(rst),
    .I_req0_valid(v0), .I_req1_valid(v1),
    .O_req0_ready(b_rdy0), .O_req1_ready(b_rdy1),
    .I_req0_op(op0), .I_req1_op(op1),
    .I_req0_s1(a0), .I_req0_s2(b0), .I_req1_s1(a1), .I_req1_s2(b1),
    .O_alu_en(b_en), .O_alu_op(b_op), .O_alu_s1(b_s1), .O_alu_s2(b_s2),
    .I_alu_busy(b_busy_in), .I_alu_data(b_data_in),
    .I_alu_lt(1'b0), .I_alu_ltu(1'b0), .I_alu_eq(1'b0),
    .O_rsp_valid(b_rsp_valid), .I_rsp_ready(rsp_ready), .O_rsp_id(b_rsp_id),
    .O_rsp_data(b_data), .O_rsp_lt(b_lt), .O_rsp_ltu(b_ltu),
    .O_rsp_eq(b_eq), .O_rsp_err(b_err)
  );

  // Behavioural ALU: result registered on enable, shifts stay busy for n+1 cycles.
  assign alu_busy = (m_cnt != 6'd0) || force_busy;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 6'd0; m_data <= 32'h0; m_lt <= 1'b0; m_ltu <= 1'b0; m_eq <= 1'b0;
    end else if (m_cnt != 6'd0) begin
      m_cnt <= m_cnt - 6'd1;
    end else if (alu_en) begin
      case (alu_op)
        ALUOP_ADD:  m_data <= alu_s1 + alu_s2;
        ALUOP_SUB:  m_data <= alu_s1 - alu_s2;
        ALUOP_SLL:  m_data <= alu_s1 << alu_s2[4:0];
        ALUOP_SLT:  m_data <= {31'h0, $signed(alu_s1) < $signed(alu_s2)};
        ALUOP_SLTU: m_data <= {31'h0, alu_s1 < alu_s2};
        ALUOP_XOR:  m_data <= alu_s1 ^ alu_s2;
        ALUOP_SRL:  m_data <= alu_s1 >> alu_s2[4:0];
        ALUOP_SRA:  m_data <= $signed(alu_s1) >>> alu_s2[4:0];
        ALUOP_OR:   m_data <= alu_s1 | alu_s2;
        ALUOP_AND:  m_data <= alu_s1 & alu_s2;
        default:    m_data <= 32'h0;
      endcase
      m_lt  <= $signed(alu_s1) < $signed(alu_s2);
      m_ltu <= alu_s1 < alu_s2;
      m_eq  <= alu_s1 == alu_s2;
      if (alu_op == ALUOP_SLL || alu_op == ALUOP_SRL || alu_op == ALUOP_SRA)
        m_cnt <= {1'b0, alu_s2[4:0]} + 6'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from a single port; checks grant, latency from grant, payload.
  task automatic do_op(input string tag, input int port, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                       input logic [31:0] exp_data, input logic [2:0] exp_flags,
                       input logic exp_err, input logic chk_en);
    int lat;
    logic en_ok;
    @(negedge clk);
    if (port == 0) begin v0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else           begin v1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    #1;
    chk({tag, "_ready"}, {31'h0, (port == 0) ? rdy0 : rdy1}, 32'h1);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    lat = 1; en_ok = 1'b1;
    while (!rsp_valid && lat < 100) begin
      if (alu_busy && !alu_en) en_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, rsp_data, exp_data);
    chk({tag, "_id"}, {31'h0, rsp_id}, 32'(port));
    chk({tag, "_flags"}, {29'h0, rsp_lt, rsp_ltu, rsp_eq}, {29'h0, exp_flags});
    chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    if (chk_en) chk({tag, "_en_busy"}, {31'h0, en_ok}, 32'h1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int g0[16];
    int n0, bg0, bg1, lat;
    logic [31:0] snap_data;
    logic [3:0]  snap_misc;
    logic stable, no_rdy, saw_rsp;

    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1; force_busy = 1'b0;
    op0 = 4'd0; op1 = 4'd0; a0 = 32'h0; b0 = 32'h0; a1 = 32'h0; b1 = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", {30'h0, rdy1, rdy0}, 32'h0);
    chk("rst_en", {31'h0, alu_en}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp", {26'h0, rsp_id, rsp_lt, rsp_ltu, rsp_eq, rsp_err, 1'b0} | rsp_data, 32'h0);
    chk("rst_alu_op", {28'h0, alu_op}, 32'h0);
    chk("rst_alu_s", alu_s1 | alu_s2, 32'h0);

    // Single-cycle and shift latencies.
    do_op("add", 0, ALUOP_ADD, 32'd5, 32'd7, 3, 32'd12, 3'b110, 1'b0, 1'b1);
    do_op("sub", 1, ALUOP_SUB, 32'd3, 32'd5, 3, 32'hFFFF_FFFE, 3'b110, 1'b0, 1'b1);
    do_op("sll", 0, ALUOP_SLL, 32'd1, 32'd4, 8, 32'h10, 3'b110, 1'b0, 1'b1);
    do_op("sra", 0, ALUOP_SRA, 32'h8000_0000, 32'd31, 35, 32'hFFFF_FFFF, 3'b100, 1'b0, 1'b1);
    do_op("sll0", 1, ALUOP_SLL, 32'd3, 32'd0, 4, 32'd3, 3'b000, 1'b0, 1'b1);

    // Both ports valid every cycle: RR alternates, fixed priority always picks port 0.
    pulse_reset();
    v0 = 1'b1; v1 = 1'b1; op0 = ALUOP_ADD; op1 = ALUOP_ADD;
    a0 = 32'd1; b0 = 32'd2; a1 = 32'd3; b1 = 32'd4;
    n0 = 0; bg0 = 0; bg1 = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (rdy0) begin g0[n0] = 0; n0++; end
      if (rdy1) begin g0[n0] = 1; n0++; end
      if (b_rdy0) bg0++;
      if (b_rdy1) bg1++;
      @(negedge clk);
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("rr_count", 32'(n0), 32'd4);
    chk("rr_g0", 32'(g0[0]), 32'd0);
    chk("rr_g1", 32'(g0[1]), 32'd1);
    chk("rr_g2", 32'(g0[2]), 32'd0);
    chk("rr_g3", 32'(g0[3]), 32'd1);
    chk("fix_p0", 32'(bg0), 32'd4);
    chk("fix_p1", 32'(bg1), 32'd0);
    repeat (6) @(negedge clk);

    // Response back-pressure: outputs frozen, no grants while held.
    rsp_ready = 1'b0;
    op1 = ALUOP_XOR; a1 = 32'hF0F0_F0F0; b1 = 32'h0FF0_0FF0; v1 = 1'b1;
    #1;
    chk("stall_ready", {31'h0, rdy1}, 32'h1);
    @(negedge clk);
    v1 = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("stall_lat", 32'(lat), 32'd3);
    snap_data = rsp_data;
    snap_misc = {rsp_id, rsp_lt, rsp_eq, rsp_err};
    chk("stall_data", snap_data, 32'hFF00_FF00);
    v0 = 1'b1; v1 = 1'b1;
    stable = 1'b1; no_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!rsp_valid || rsp_data !== snap_data || {rsp_id, rsp_lt, rsp_eq, rsp_err} !== snap_misc)
        stable = 1'b0;
      if (rdy0 || rdy1) no_rdy = 1'b0;
      @(negedge clk);
    end
    chk("stall_stable", {31'h0, stable}, 32'h1);
    chk("stall_no_ready", {31'h0, no_rdy}, 32'h1);
    rsp_ready = 1'b1;
    #1;
    chk("accept_no_grant", {30'h0, rdy1, rdy0}, 32'h0);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    repeat (6) @(negedge clk);

    // Reset in the middle of a long shift: no response ever appears.
    op0 = ALUOP_SLL; a0 = 32'h1; b0 = 32'd20; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", {31'h0, alu_busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_en", {31'h0, alu_en}, 32'h0);
    chk("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_op", {28'h0, alu_op}, 32'h0);
    chk("mid_rst_s", alu_s1 | alu_s2, 32'h0);
    saw_rsp = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("mid_no_rsp", {31'h0, saw_rsp}, 32'h0);

    // Busy stuck high: abort after 40 WAIT cycles with zeroed data and flags.
    force_busy = 1'b1;
    do_op("tmo", 0, ALUOP_ADD, 32'd1, 32'd1, 42, 32'h0, 3'b000, 1'b1, 1'b0);
    chk("tmo_en_low", {31'h0, alu_en}, 32'h0);
    force_busy = 1'b0;
    pulse_reset();
    #1;
    chk("tmo_rst_err", {31'h0, rsp_err}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
